// File: rtl/fft_pkg.sv
// Shared constants, bit-reverse helper and read-FSM encoding for the FFT output stage.
package fft_pkg;

    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;
    localparam int FFT_DW    = 24;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_t;

    // Reverse the low w bits of a; bits above w are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < w; i++) begin
            r[i] = a[w - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One reorder bank: N words, single write port, registered read port.
module fft_reorder_bank #(
    parameter int N     = 64,
    parameter int LOG2N = 6,
    parameter int W     = 48
) (
    input  logic             clk,
    input  logic             we,
    input  logic [LOG2N-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic             re,
    input  logic [LOG2N-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [N];

    // Write port: store the incoming sample at its reordered address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: rdata holds its value until the next enabled read.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural-order bins out.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = FFT_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] din_r,
    input  logic signed [DW-1:0] din_i,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [DW-1:0] dout_r,
    output logic signed [DW-1:0] dout_i,
    output logic                 out_last,
    output logic                 overflow
);

    localparam logic [LOG2N-1:0] LastAddr = LOG2N'(N - 1);

    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] wr_addr;
    logic [LOG2N-1:0] rd_cnt;
    logic             wb;
    logic             rb;
    logic [1:0]       full;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;
    rd_state_t        state;

    // Read pipeline stage: a RAM word is waiting in a bank's read register.
    logic             pend;
    logic             pend_last;
    logic             pend_bank;
    logic [2*DW-1:0]  rdata0;
    logic [2*DW-1:0]  rdata1;
    logic [2*DW-1:0]  pend_data;

    logic             accept;
    logic             adv;
    logic             issue;
    logic             rd_wrap;
    logic             load_out;

    assign accept    = in_valid && !full[wb];
    assign wr_addr   = LOG2N'(bitrev(32'(wr_cnt), LOG2N));
    // A read may be issued when the RAM register is free or will move on this edge.
    assign adv       = !pend || !out_valid || out_ready;
    assign load_out  = pend && (!out_valid || out_ready);
    assign rd_wrap   = issue && (rd_cnt == LastAddr);
    assign pend_data = pend_bank ? rdata1 : rdata0;

    // Read issue decision; DRAIN may start the next bank early to keep frames gapless.
    always_comb begin
        issue = 1'b0;
        unique case (state)
            IDLE, DRAIN: issue = full[rb] && adv;
            READ:        issue = adv;
            default:     issue = 1'b0;
        endcase
    end

    // Full-flag set/clear requests per bank; the two banks never collide.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (accept && (wr_cnt == LastAddr)) begin
            full_set[wb] = 1'b1;
        end
        if (rd_wrap) begin
            full_clr[rb] = 1'b1;
        end
    end

    // Write side: counter, bank pointer and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            wb       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == LastAddr) begin
                    wb <= ~wb;
                end
            end
            if (in_valid && full[wb]) begin
                overflow <= 1'b1;
            end
        end
    end

    // Bank full flags, updated independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
        end
    end

    // Read FSM together with the read counter and RAM pipeline tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            rb        <= 1'b0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            pend_bank <= 1'b0;
        end else begin
            if (issue) begin
                rd_cnt    <= rd_cnt + 1'b1;
                pend_last <= (rd_cnt == LastAddr);
                pend_bank <= rb;
            end
            pend <= issue || (pend && !load_out);
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (rd_wrap) begin
                        rb    <= ~rb;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        state <= READ;
                    end else if (out_valid && out_ready && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: loads from the RAM stage, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            dout_r    <= '0;
            dout_i    <= '0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_last  <= pend_last;
            dout_r    <= pend_data[2*DW-1:DW];
            dout_i    <= pend_data[DW-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    fft_reorder_bank #(
        .N     (N),
        .LOG2N (LOG2N),
        .W     (2 * DW)
    ) u_bank0 (
        .clk   (clk),
        .we    (accept && !wb),
        .waddr (wr_addr),
        .wdata ({din_r, din_i}),
        .re    (issue && !rb),
        .raddr (rd_cnt),
        .rdata (rdata0)
    );

    fft_reorder_bank #(
        .N     (N),
        .LOG2N (LOG2N),
        .W     (2 * DW)
    ) u_bank1 (
        .clk   (clk),
        .we    (accept && wb),
        .waddr (wr_addr),
        .wdata ({din_r, din_i}),
        .re    (issue && rb),
        .raddr (rd_cnt),
        .rdata (rdata1)
    );

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder buffer for the 64-point FFT pipeline: it takes the bit-reversed complex sample stream produced by the final butterfly/shift stage and delivers each frame in natural frequency order (bin 0..63). Two 64-entry banks operate ping-pong, so one frame fills while the previous one drains and the stream stays continuous. The block sits at the tail of the FFT datapath, immediately after the last shift/butterfly stage.

## Interface
- `N`, default 64: frame length, a power of two.
- `LOG2N`, default 6: address width, equal to log2(N).
- `DW`, default 24: width of each of the real and imaginary parts (signed).
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a sample is present on `din_r`/`din_i` this cycle.
- `din_r` in DW: real part, signed, bit-reversed arrival order.
- `din_i` in DW: imaginary part, signed.
- `out_ready` in 1: downstream accepts the output sample this cycle.
- `out_valid` out 1: `dout_r`/`dout_i` hold a valid sample.
- `dout_r` out DW: real part, signed, natural order.
- `dout_i` out DW: imaginary part, signed.
- `out_last` out 1: high together with `out_valid` on bin N-1.
- `overflow` out 1: sticky flag, set when an input sample is dropped.

## Operation
- **Write side.** Write counter `wr_cnt` (LOG2N bits) and write-bank pointer `wb`.
  - Each accepted `in_valid` sample is written to bank `wb` at address `bitrev(wr_cnt)`, then `wr_cnt` increments.
  - On wrap (63 -> 0), bank `wb` is marked full and `wb` toggles.
- **Input gaps.** Gaps in `in_valid` are allowed anywhere within a frame. The write side simply holds its state.
- **Overflow.** If `in_valid` is high while bank `wb` is still full (the reader has not drained it):
  - the sample is dropped;
  - `wr_cnt` does not advance;
  - `overflow` is set to 1 and stays 1 until reset.
- **Read side FSM.**
  - `IDLE`: waits for bank `rb` to be full, then goes to `READ`.
  - `READ`: the read counter `rd_cnt` issues sequential addresses 0..N-1 from bank `rb`. An address advances only when the output register is empty or is being consumed this cycle (`out_ready`).
  - After the read of address N-1 is issued: bank `rb` full is cleared, `rb` toggles, and the FSM goes to `DRAIN`.
  - `DRAIN`: the final sample is presented. On its handshake the FSM goes to `READ` if the new `rb` bank is full, otherwise to `IDLE`.
- **Output register.**
  - Once `out_valid` is high, `dout_r`, `dout_i` and `out_last` stay stable until `out_valid && out_ready`.
  - There is no combinational path from `out_ready` to `out_valid`.
- **Simultaneous events.** A bank that becomes full on the same edge that the reader frees the other bank is legal. The full flags of the two banks are independent.
- **Arithmetic.** Data passes through unmodified; there is no scaling or rounding. `bitrev` reverses the LOG2N address bits.

## Timing
- **Reset values.** `out_valid`=0, `out_last`=0, `overflow`=0, `dout_r`=0, `dout_i`=0. Also cleared: `wr_cnt`, `rd_cnt`, `wb`, `rb`, both full flags. The FSM starts in `IDLE`.
- **Reset mid-frame.** Discards all buffered data. No output appears until a fresh 64-sample frame has been written.
- **Latency.** The RAM read is synchronous. The 64th sample is written at edge E.
  - The full flag is seen in the cycle after E; the read is issued at edge E+1.
  - `out_valid` is high from edge E+2 with bin 0.
- **Throughput.** With `out_ready` held high, one output per cycle, so 64 consecutive cycles per frame.
- **Continuous streaming.** With `in_valid` continuously high and `out_ready` high, there are zero gaps between output frames and `overflow` never sets.
- **Write timing.** Writes take effect on the accepting edge. A read of the same bank cannot happen before that bank is full.

## Structure
- **Shared package `fft_pkg`**:
  - constants `FFT_N`=64, `FFT_LOG2N`=6, `FFT_DW`=24;
  - the `bitrev` function;
  - the read-FSM state encoding (`IDLE`, `READ`, `DRAIN`).
- **Sub-module `fft_reorder_bank`**: one bank of N x 2·DW single-port-write, registered-read RAM, instantiated twice. All control logic stays in the top module.

## Test plan
- **Single frame.**
  - Stimulus: after reset, 64 back-to-back samples with `din_r`=k and `din_i`=-k for arrival index k; `out_ready`=1.
  - Required: outputs `dout_r`=bitrev(n) and `dout_i`=-bitrev(n) for n=0..63; first `out_valid` 2 cycles after the last input; `out_last` only on n=63.
- **Streaming.**
  - Stimulus: 4 back-to-back frames, `out_ready`=1.
  - Required: 256 consecutive `out_valid` cycles with no bubbles; all bins correct; `overflow`=0.
- **Backpressure.**
  - Stimulus: `out_ready` toggled at random at 50% during a frame.
  - Required: every bin is delivered exactly once, in order; data stays stable while stalled.
- **Overflow.**
  - Stimulus: `out_ready`=0 while 3 full frames are pushed.
  - Required: `overflow`=1 from the first sample of frame 3; after `out_ready`=1, frames 1 and 2 emerge intact.
- **Input gaps.**
  - Stimulus: `in_valid` at a 1-in-3 duty cycle.
  - Required: correct natural-order output; `out_valid` begins only after the 64th sample.
- **Reset mid-frame.**
  - Stimulus: assert `rst_n`=0 after 30 samples, then send a new full frame.
  - Required: outputs are at their reset values during reset; only the new frame is output, correctly ordered.
